// File: rtl/ram_slot_arbiter.sv
// Time-slot arbiter for the shared 64x4 scratch RAM: one owner (core or host) per 8-clk machine cycle.
// The slot decision is taken on the edge that wraps phase 7->0, so the new owner is visible from phase 0.
module ram_slot_arbiter #(
    parameter int unsigned AW           = 6,
    parameter int unsigned DW           = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          RESET,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [2:0]    phase,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCore = 2'b01,
        StHost = 2'b10
    } slot_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    slot_e      state_q;
    slot_e      state_d;
    logic [2:0] phase_q;
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       we_q;
    logic       grant_host;
    logic       grant_core;

    always_comb begin
        grant_host = host_req && (!core_req || (starve_q == StarveMax));
        grant_core = !grant_host && core_req;

        state_d = StIdle;
        if (grant_host) begin
            state_d = StHost;
        end else if (grant_core) begin
            state_d = StCore;
        end

        starve_d = starve_q;
        if (grant_host || !host_req) begin
            starve_d = '0;
        end else if (grant_core && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            phase_q    <= '0;
            state_q    <= StIdle;
            starve_q   <= '0;
            we_q       <= 1'b0;
            core_stall <= 1'b0;
            host_ack   <= 1'b0;
            mem_we     <= 1'b0;
            host_rdata <= '0;
            core_rdata <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            phase_q  <= phase_q + 3'd1;
            mem_we   <= 1'b0;
            host_ack <= 1'b0;

            unique case (phase_q)
                3'd7: begin
                    state_q    <= state_d;
                    starve_q   <= starve_d;
                    core_stall <= grant_host && core_req;
                    unique case (state_d)
                        StHost: begin
                            we_q      <= host_we;
                            mem_addr  <= host_addr;
                            mem_wdata <= host_wdata;
                        end
                        StCore: begin
                            we_q      <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                        end
                        default: begin
                            // Address and data bus hold their last value while idle
                            we_q <= 1'b0;
                        end
                    endcase
                end
                3'd4: begin
                    if (state_q == StCore) begin
                        core_rdata <= mem_rdata;
                    end
                end
                3'd5: begin
                    mem_we <= (state_q != StIdle) && we_q;
                end
                3'd6: begin
                    if (state_q == StHost) begin
                        host_ack <= 1'b1;
                        if (!we_q) begin
                            host_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign phase = phase_q;
    assign owner = state_q;

    mem_we_in_slot_a: assert property (@(posedge clk) disable iff (!RESET)
        mem_we |-> (phase_q == 3'd6) && (state_q != StIdle));

    host_ack_in_slot_a: assert property (@(posedge clk) disable iff (!RESET)
        host_ack |-> (phase_q == 3'd7) && (state_q == StHost));

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Directed bench for ram_slot_arbiter: per-machine-cycle vector table plus hand sequences
// for early host drop and reset asserted in the middle of a slot.
module tb_ram_slot_arbiter;

    localparam logic [1:0] OIdle = 2'b00;
    localparam logic [1:0] OCore = 2'b01;
    localparam logic [1:0] OHost = 2'b10;

    logic       clk;
    logic       RESET;
    logic       core_req;
    logic       core_we;
    logic [5:0] core_addr;
    logic [3:0] core_wdata;
    logic [3:0] core_rdata;
    logic       core_stall;
    logic       host_req;
    logic       host_we;
    logic [5:0] host_addr;
    logic [3:0] host_wdata;
    logic       host_ack;
    logic [3:0] host_rdata;
    logic [5:0] mem_addr;
    logic       mem_we;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic [2:0] phase;
    logic [1:0] owner;

    logic [3:0] ram [0:63];
    logic       ram_init;

    int n_chk;
    int n_fail;

    ram_slot_arbiter #(
        .AW(6),
        .DW(4),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .core_req(core_req),
        .core_we(core_we),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .host_req(host_req),
        .host_we(host_we),
        .host_addr(host_addr),
        .host_wdata(host_wdata),
        .host_ack(host_ack),
        .host_rdata(host_rdata),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .phase(phase),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model: combinational read, write on the edge ending the strobe clk
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= (i == 63) ? 4'h7 : 4'h0;
        end else if (mem_we === 1'b1) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        logic       creq;
        logic       cwe;
        logic [5:0] caddr;
        logic [3:0] cwd;
        logic       hreq;
        logic       hwe;
        logic [5:0] haddr;
        logic [3:0] hwd;
        logic [1:0] owner;
        logic       stall;
        int         we;
        int         ack;
        logic [3:0] hrd;
        logic [3:0] crd;
        logic [5:0] maddr;
    } vec_t;

    vec_t vecs [0:17];

    function automatic vec_t mk(input logic creq, input logic cwe, input logic [5:0] caddr,
                                input logic [3:0] cwd, input logic hreq, input logic hwe,
                                input logic [5:0] haddr, input logic [3:0] hwd,
                                input logic [1:0] own, input logic stall, input int we,
                                input int ack, input logic [3:0] hrd, input logic [3:0] crd,
                                input logic [5:0] maddr);
        vec_t v;
        v.creq = creq;  v.cwe = cwe;  v.caddr = caddr;  v.cwd = cwd;
        v.hreq = hreq;  v.hwe = hwe;  v.haddr = haddr;  v.hwd = hwd;
        v.owner = own;  v.stall = stall;  v.we = we;  v.ack = ack;
        v.hrd = hrd;  v.crd = crd;  v.maddr = maddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sync7(input string tag);
        int n;
        n = 0;
        while (phase !== 3'd7 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(phase), 32'd7);
    endtask

    // Entered at the phase-7 negedge; drives one machine cycle and ends at the next phase-7 negedge
    task automatic apply_cycle(input vec_t v, input string tag);
        int we_cnt, ack_cnt, we_bad, ack_bad, own_bad, stall_bad;
        logic [3:0] exp_wd;
        core_req = v.creq;  core_we = v.cwe;  core_addr = v.caddr;  core_wdata = v.cwd;
        host_req = v.hreq;  host_we = v.hwe;  host_addr = v.haddr;  host_wdata = v.hwd;
        exp_wd = (v.owner == OHost) ? v.hwd : v.cwd;
        we_cnt = 0;  ack_cnt = 0;  we_bad = 0;  ack_bad = 0;  own_bad = 0;  stall_bad = 0;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            if (p == 0) begin
                chk({tag, ".phase0"}, 32'(phase), 32'd0);
                chk({tag, ".owner"}, 32'(owner), 32'(v.owner));
                chk({tag, ".stall"}, 32'(core_stall), 32'(v.stall));
            end
            if (owner !== v.owner) own_bad++;
            if (core_stall !== v.stall) stall_bad++;
            if (mem_we === 1'b1) begin
                we_cnt++;
                if (phase !== 3'd6 || mem_wdata !== exp_wd) we_bad++;
            end
            if (host_ack === 1'b1) begin
                ack_cnt++;
                if (phase !== 3'd7) ack_bad++;
            end
        end
        chk({tag, ".we_count"}, 32'(we_cnt), 32'(v.we));
        chk({tag, ".we_timing"}, 32'(we_bad), 32'd0);
        chk({tag, ".ack_count"}, 32'(ack_cnt), 32'(v.ack));
        chk({tag, ".ack_timing"}, 32'(ack_bad), 32'd0);
        chk({tag, ".owner_held"}, 32'(own_bad), 32'd0);
        chk({tag, ".stall_held"}, 32'(stall_bad), 32'd0);
        chk({tag, ".host_rdata"}, 32'(host_rdata), 32'(v.hrd));
        chk({tag, ".core_rdata"}, 32'(core_rdata), 32'(v.crd));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(v.maddr));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, acks, wes;
        n_chk = 0;
        n_fail = 0;
        RESET = 1'b0;
        ram_init = 1'b1;
        core_req = 0;  core_we = 0;  core_addr = '0;  core_wdata = '0;
        host_req = 0;  host_we = 0;  host_addr = '0;  host_wdata = '0;

        // RAM starts zeroed with 0x3F = 7
        vecs[0]  = mk(0, 0, 6'h00, 4'h0, 1, 1, 6'h15, 4'hA, OHost, 0, 1, 1, 4'h0, 4'h0, 6'h15);
        vecs[1]  = mk(0, 0, 6'h00, 4'h0, 1, 0, 6'h15, 4'h0, OHost, 0, 0, 1, 4'hA, 4'h0, 6'h15);
        vecs[2]  = mk(0, 0, 6'h00, 4'h0, 0, 0, 6'h00, 4'h0, OIdle, 0, 0, 0, 4'hA, 4'h0, 6'h15);
        vecs[3]  = vecs[2];
        vecs[4]  = vecs[2];
        vecs[5]  = mk(1, 0, 6'h3F, 4'h0, 1, 1, 6'h20, 4'h5, OCore, 0, 0, 0, 4'hA, 4'h7, 6'h3F);
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = vecs[5];
        vecs[9]  = mk(1, 0, 6'h3F, 4'h0, 1, 1, 6'h20, 4'h5, OHost, 1, 1, 1, 4'hA, 4'h7, 6'h20);
        vecs[10] = mk(1, 1, 6'h3F, 4'h9, 0, 0, 6'h00, 4'h0, OCore, 0, 1, 0, 4'hA, 4'h7, 6'h3F);
        vecs[11] = mk(0, 0, 6'h00, 4'h0, 1, 0, 6'h20, 4'h0, OHost, 0, 0, 1, 4'h5, 4'h7, 6'h20);
        vecs[12] = mk(1, 0, 6'h3F, 4'h0, 0, 0, 6'h00, 4'h0, OCore, 0, 0, 0, 4'h5, 4'h9, 6'h3F);
        vecs[13] = mk(1, 0, 6'h00, 4'h0, 1, 0, 6'h3F, 4'h0, OCore, 0, 0, 0, 4'h5, 4'h0, 6'h00);
        vecs[14] = mk(1, 0, 6'h00, 4'h0, 0, 0, 6'h00, 4'h0, OCore, 0, 0, 0, 4'h5, 4'h0, 6'h00);
        vecs[15] = mk(0, 0, 6'h00, 4'h0, 1, 1, 6'h3F, 4'h3, OHost, 0, 1, 1, 4'h5, 4'h0, 6'h3F);
        vecs[16] = mk(1, 1, 6'h3F, 4'h6, 0, 0, 6'h00, 4'h0, OCore, 0, 1, 0, 4'h5, 4'h3, 6'h3F);
        vecs[17] = mk(0, 0, 6'h00, 4'h0, 1, 0, 6'h3F, 4'h0, OHost, 0, 0, 1, 4'h6, 4'h3, 6'h3F);

        @(negedge clk);
        @(negedge clk);
        ram_init = 1'b0;
        chk("rst.phase", 32'(phase), 32'd0);
        chk("rst.owner", 32'(owner), 32'(OIdle));
        chk("rst.stall", 32'(core_stall), 32'd0);
        chk("rst.ack", 32'(host_ack), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.host_rdata", 32'(host_rdata), 32'd0);
        chk("rst.core_rdata", 32'(core_rdata), 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd0);
        chk("rst.mem_wdata", 32'(mem_wdata), 32'd0);

        @(negedge clk);
        RESET = 1'b1;
        sync7("sync.start");

        for (int i = 0; i < 18; i++) apply_cycle(vecs[i], $sformatf("v%0d", i));

        // Host request pulse that misses the phase-0 decision edge must never be granted
        core_req = 0;  host_req = 0;  host_we = 0;  host_addr = 6'h15;
        acks = 0;  wes = 0;
        for (int p = 0; p < 16; p++) begin
            @(negedge clk);
            if (p == 1) host_req = 1'b1;
            if (p == 5) host_req = 1'b0;
            if (p == 0 || p == 8) chk($sformatf("drop.owner%0d", p), 32'(owner), 32'(OIdle));
            if (host_ack === 1'b1) acks++;
            if (mem_we === 1'b1) wes++;
        end
        chk("drop.acks", 32'(acks), 32'd0);
        chk("drop.mem_we", 32'(wes), 32'd0);
        chk("drop.host_rdata", 32'(host_rdata), 32'h6);

        // Reset at phase 4 of a host write: no strobe, no ack, RAM untouched
        host_req = 1;  host_we = 1;  host_addr = 6'h30;  host_wdata = 4'hF;
        bad = 0;
        for (int p = 0; p < 5; p++) begin
            @(negedge clk);
            if (p == 0) chk("midrst.owner_before", 32'(owner), 32'(OHost));
            if (mem_we === 1'b1 || host_ack === 1'b1) bad++;
        end
        RESET = 1'b0;
        #1;
        chk("midrst.phase", 32'(phase), 32'd0);
        chk("midrst.owner", 32'(owner), 32'(OIdle));
        chk("midrst.mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst.host_rdata", 32'(host_rdata), 32'd0);
        host_req = 0;  host_we = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_we === 1'b1 || host_ack === 1'b1) bad++;
        end
        RESET = 1'b1;
        chk("midrst.phase_release", 32'(phase), 32'd0);
        chk("midrst.owner_release", 32'(owner), 32'(OIdle));
        sync7("sync.midrst");
        chk("midrst.no_strobe_or_ack", 32'(bad), 32'd0);
        chk("midrst.ram30", 32'(ram[6'h30]), 32'd0);

        apply_cycle(mk(0, 0, 6'h00, 4'h0, 1, 0, 6'h30, 4'h0, OHost, 0, 0, 1, 4'h0, 4'h0, 6'h30),
                    "post.host_read");
        apply_cycle(mk(1, 0, 6'h3F, 4'h0, 0, 0, 6'h00, 4'h0, OCore, 0, 0, 0, 4'h0, 4'h6, 6'h3F),
                    "post.core_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
